// File: rtl/next_pc_unit_pkg.sv
// Shared CPU definitions for next-PC selection: source encoding and sequential increment.
package next_pc_unit_pkg;

  typedef enum logic [2:0] {
    SRC_MISS   = 3'd0,
    SRC_JUMP   = 3'd1,
    SRC_RET    = 3'd2,
    SRC_BRANCH = 3'd3,
    SRC_SEQ    = 3'd4
  } pc_src_e;

  localparam int PC_INC = 4;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push on full overwrites the oldest entry and sets a sticky overflow.
// Top-of-stack is a combinational read of registered state; caller never pushes and pops together.
module return_addr_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_dat_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == FULL_CNT);
  assign overflow_o = ovf_q;
  // ptr_q names the next free slot, so the top lives one below it.
  assign top_o      = mem_q[ptr_q - PTR_W'(1)];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full_o) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection with fixed-priority redirect sources and a return-address stack.
// oNewPC is combinational; oPC follows it one cycle later unless stalled.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 OFFSET_W  = 26,
  parameter int                 RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iStall,
  input  logic [OFFSET_W-1:0] iOffset,
  input  logic                iBranchCmd,
  input  logic [ADDR_W-1:0]   iBranchAddr,
  input  logic                iBranchMissCmd,
  input  logic [ADDR_W-1:0]   iBranchMissAddr,
  input  logic                iJumpCmd,
  input  logic                iCallCmd,
  input  logic                iRetCmd,
  input  logic [ADDR_W-1:0]   iRetAddr,
  output logic [ADDR_W-1:0]   oPC,
  output logic [ADDR_W-1:0]   oNewPC,
  output logic                oRasEmpty,
  output logic                oRasFull,
  output logic                oRasOverflow,
  output logic                oRasUnderflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq, jump_tgt, ret_tgt, ras_top;
  logic              ras_push, ras_pop, ras_empty, advance;
  pc_src_e           sel;

  assign seq      = pc_q + ADDR_W'(PC_INC);
  assign jump_tgt = {seq[ADDR_W-1:OFFSET_W], iOffset};
  assign ret_tgt  = ras_empty ? iRetAddr : ras_top;
  assign advance  = !iReset && !iStall;

  always_comb begin
    sel = SRC_SEQ;
    if      (iBranchMissCmd)        sel = SRC_MISS;
    else if (iJumpCmd || iCallCmd)  sel = SRC_JUMP;
    else if (iRetCmd)               sel = SRC_RET;
    else if (iBranchCmd)            sel = SRC_BRANCH;
  end

  always_comb begin
    oNewPC = seq;
    case (sel)
      SRC_MISS:   oNewPC = iBranchMissAddr;
      SRC_JUMP:   oNewPC = jump_tgt;
      SRC_RET:    oNewPC = ret_tgt;
      SRC_BRANCH: oNewPC = iBranchAddr;
      default:    oNewPC = seq;
    endcase
  end

  // A call is a jump that also links; masked commands never touch the stack.
  assign ras_push      = advance && (sel == SRC_JUMP) && iCallCmd;
  assign ras_pop       = advance && (sel == SRC_RET) && !ras_empty;
  assign oRasUnderflow = advance && (sel == SRC_RET) && ras_empty;

  assign pc_d = iStall ? pc_q : oNewPC;

  always_ff @(posedge iClk) begin
    if (iReset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign oPC       = pc_q;
  assign oRasEmpty = ras_empty;

  return_addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk_i      (iClk),
    .rst_i      (iReset),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_dat_i (seq),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .full_o     (oRasFull),
    .overflow_o (oRasOverflow)
  );

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/address width.
REQ-002 SHALL have parameter OFFSET_W, default 26, jump offset width; legal range 1..ADDR_W-1.
REQ-003 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 SHALL have port iClk, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have port iReset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port iStall, input, 1, freeze PC and RAS this cycle.
REQ-008 SHALL have port iOffset, input, OFFSET_W, jump/call target low bits.
REQ-009 SHALL have port iBranchCmd and port iBranchAddr, inputs, 1 and ADDR_W, predicted-taken branch and its target.
REQ-010 SHALL have port iBranchMissCmd and port iBranchMissAddr, inputs, 1 and ADDR_W, mispredict redirect and its target.
REQ-011 SHALL have port iJumpCmd and port iCallCmd, inputs, 1 each, plain jump and jump-and-link.
REQ-012 SHALL have port iRetCmd and port iRetAddr, inputs, 1 and ADDR_W, return and fallback target used when the RAS is empty.
REQ-013 SHALL have port oPC, output, ADDR_W, registered current PC.
REQ-014 SHALL have port oNewPC, output, ADDR_W, combinational next PC.
REQ-015 SHALL have ports oRasEmpty, oRasFull and oRasOverflow, outputs, 1 each; oRasOverflow is sticky.
REQ-016 SHALL have port oRasUnderflow, output, 1, single-cycle pulse on a return issued while the RAS is empty.

Function
REQ-017 SHALL define seq = oPC + 4, computed modulo 2^ADDR_W so that it wraps at the top of the address space.
REQ-018 SHALL form the jump/call target as {seq[ADDR_W-1:OFFSET_W], iOffset}, with no shift applied.
REQ-019 SHALL select oNewPC by fixed priority: iBranchMissCmd first, then iJumpCmd or iCallCmd (jump target), then iRetCmd, then iBranchCmd, then seq.
REQ-020 SHALL select the return target as the RAS top entry when the RAS is non-empty, and as iRetAddr when it is empty.
REQ-021 SHALL load oNewPC into oPC on each edge where iStall is 0; oPC holds its value when iStall is 1 (one-cycle latency from command to oPC).
REQ-022 SHALL compute oNewPC during a stall, but no PC, RAS or flag state SHALL change.
REQ-023 SHALL push seq onto the RAS when iCallCmd is the selected source.
REQ-024 SHALL pop the RAS when iRetCmd is the selected source and the RAS is non-empty.
REQ-025 SHALL make no RAS change when a command is masked by a higher-priority command (for example, call+ret together: push only; miss+call: no push).
REQ-026 SHALL, on a push while full, overwrite the oldest entry (circular wrap), keep the count saturated at RAS_DEPTH, and set oRasOverflow.
REQ-027 SHALL, on a return while empty, leave the count at 0 and assert oRasUnderflow for that cycle.
REQ-028 SHALL report oRasEmpty = (count == 0) and oRasFull = (count == RAS_DEPTH), both derived from registered state.
REQ-029 SHALL leave the RAS unchanged on iBranchMissCmd; branch-miss recovery of the RAS is out of scope.

Reset
REQ-030 SHALL, on iReset, set oPC = RESET_PC, RAS count = 0, RAS pointer = 0, oRasOverflow = 0 and oRasUnderflow = 0; RAS entry contents are don't-care.
REQ-031 SHALL give iReset priority over iStall and over every command; a reset mid-sequence discards all RAS contents.
REQ-032 SHALL drive oNewPC = seq derived from RESET_PC in the first cycle after reset when no command is asserted.

Structure
REQ-033 SHALL place the source-select encoding (MISS, JUMP, RET, BRANCH, SEQ) and the PC increment constant of 4 in the shared CPU package.
REQ-034 SHALL implement the RAS as one sub-module, return_addr_stack, with push, pop, top, empty, full and overflow signals, parametrised by ADDR_W and RAS_DEPTH.

Verification
REQ-035 SHALL cover reset: after reset with no commands for 3 cycles, oPC = 0, 4, 8 and oRasEmpty = 1.
REQ-036 SHALL cover call/return: with oPC = 0x100, a call with iOffset = 0x40 gives oPC = 0x40 on the next cycle; a later return gives oPC = 0x104 and oRasEmpty = 1.
REQ-037 SHALL cover RAS overflow: 9 calls issued from PCs 0x0, 0x10 .. 0x80 (RAS_DEPTH = 8) set oRasOverflow = 1; 8 subsequent returns yield 0x84, 0x74 .. 0x14; a 9th return yields iRetAddr with oRasUnderflow = 1.
REQ-038 SHALL cover the all-asserted case: iBranchMissCmd plus every other command with iBranchMissAddr = 0x2000 gives oPC = 0x2000 and an unchanged RAS count.
REQ-039 SHALL cover stall: a call held while iStall = 1 for 2 cycles leaves oPC and the RAS count unchanged; when iStall drops, exactly one push occurs.
REQ-040 SHALL cover wrap: with oPC = 0xFFFFFFFC and no command, the next oPC = 0x00000000.
